// File: rtl/cnn_array_pkg.sv
// Shared types and helpers for the CNN systolic array edge logic.
//   skew_mode_e : SKEW staggers rows on the PE input edge, DESKEW re-aligns
//                 a skewed wavefront on the PE output edge.
//   word_t      : default data word of the array.
//   skew_depth  : number of stages a row's delay line needs so both the SKEW
//                 tap (stage r) and the DESKEW tap (stage ROWS-1-r) exist.
//   tap_width   : select width for a delay line of a given depth.
package cnn_array_pkg;

   localparam int DW_DEFAULT = 16;

   typedef enum logic {
      SKEW   = 1'b0,
      DESKEW = 1'b1
   } skew_mode_e;

   typedef logic [DW_DEFAULT-1:0] word_t;

   function automatic int skew_depth(input int r, input int rows);
      return (r + 1 > rows - r) ? r + 1 : rows - r;
   endfunction

   // A one-stage line still gets a 1-bit select so ports never collapse to zero width.
   function automatic int tap_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/skew_buffer_array_if.sv
// Bus bundle of the skew buffer array.
//   en        advance (0 = whole array stalls)
//   flush     synchronous clear of all in-flight entries
//   mode_req  requested mode (0 = SKEW, 1 = DESKEW)
//   in_vld    data_in slice valid
//   data_in   one word per row
//   data_out  delayed word per row
//   out_vld   per-row valid of data_out
//   mode_q    active mode
//   busy      any valid entry in flight
//   all_vld   AND of out_vld
// master drives the request side, slave is the array itself.
interface skew_buffer_array_if #(
   parameter int ROWS = 25,
   parameter int DW   = 16
);

   logic            en;
   logic            flush;
   logic            mode_req;
   logic            in_vld;
   logic [DW-1:0]   data_in  [ROWS];
   logic [DW-1:0]   data_out [ROWS];
   logic [ROWS-1:0] out_vld;
   logic            mode_q;
   logic            busy;
   logic            all_vld;

   modport master (
      output en, flush, mode_req, in_vld, data_in,
      input  data_out, out_vld, mode_q, busy, all_vld
   );

   modport slave (
      input  en, flush, mode_req, in_vld, data_in,
      output data_out, out_vld, mode_q, busy, all_vld
   );

endinterface

// File: rtl/skew_delay_line.sv
// One row of the skew buffer: a DEPTH-stage shift line of {vld, data}.
// Ports:
//   clk, nrst   clock / async active-low reset
//   en          advance the line; 0 holds every stage
//   flush       clear every stage at the next edge (wins over en)
//   vld_in      valid of the word presented on data_in
//   data_in     word captured into stage 0 (forced to 0 when not valid)
//   tap_sel     stage index driven onto vld_out/data_out
//   vld_out     valid bit of the tapped stage
//   data_out    data of the tapped stage
//   any_vld     OR of all stage valid bits, tapped or not
module skew_delay_line
   import cnn_array_pkg::*;
#(
   parameter int DW    = 16,
   parameter int DEPTH = 1,
   localparam int TW   = tap_width(DEPTH)
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          en,
   input  logic          flush,
   input  logic          vld_in,
   input  logic [DW-1:0] data_in,
   input  logic [TW-1:0] tap_sel,
   output logic          vld_out,
   output logic [DW-1:0] data_out,
   output logic          any_vld
);

   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;
   logic [DW-1:0]    data_q [DEPTH];
   logic [DW-1:0]    data_d [DEPTH];

   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      if (flush) begin
         vld_d = '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = '0;
         end
      end else if (en) begin
         // Invalid entries carry zero so an idle tap always reads 0.
         vld_d[0]  = vld_in;
         data_d[0] = vld_in ? data_in : '0;
         for (int i = 1; i < DEPTH; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   // Explicit compare mux keeps out-of-range select codes harmless on
   // non-power-of-two depths.
   always_comb begin
      vld_out  = 1'b0;
      data_out = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (tap_sel == TW'(i)) begin
            vld_out  = vld_q[i];
            data_out = data_q[i];
         end
      end
   end

   assign any_vld = |vld_q;

endmodule

// File: rtl/skew_buffer_array.sv
// Skew / de-skew buffer array at the edge of the systolic PE grid.
// SKEW delays row r by r+1 advancing edges; DESKEW delays row r by ROWS-r,
// so a wavefront skewed on the way in leaves time-aligned.
// Ports:
//   clk   clock, rising edge
//   nrst  asynchronous active-low reset
//   bus   skew_buffer_array_if.slave (en, flush, mode_req, in_vld, data_in,
//         data_out, out_vld, mode_q, busy, all_vld)
// The mode only changes when nothing is in flight and no slice is being
// captured at the same edge, so an entry is never re-tapped mid-flight.
module skew_buffer_array
   import cnn_array_pkg::*;
#(
   parameter int ROWS = 25,
   parameter int DW   = 16
) (
   input  logic                 clk,
   input  logic                 nrst,
   skew_buffer_array_if.slave   bus
);

   skew_mode_e      mode_q;
   skew_mode_e      mode_d;
   logic            busy;
   logic            capture_now;
   logic [ROWS-1:0] row_any_vld;
   logic [ROWS-1:0] row_vld;
   logic [DW-1:0]   row_data [ROWS];

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam int DEP        = skew_depth(r, ROWS);
      localparam int TW         = tap_width(DEP);
      localparam int TAP_SKEW   = r;
      localparam int TAP_DESKEW = ROWS - 1 - r;

      logic [TW-1:0] tap_sel;

      assign tap_sel = (mode_q == SKEW) ? TW'(TAP_SKEW) : TW'(TAP_DESKEW);

      skew_delay_line #(
         .DW    (DW),
         .DEPTH (DEP)
      ) u_line (
         .clk      (clk),
         .nrst     (nrst),
         .en       (bus.en),
         .flush    (bus.flush),
         .vld_in   (bus.in_vld),
         .data_in  (bus.data_in[r]),
         .tap_sel  (tap_sel),
         .vld_out  (row_vld[r]),
         .data_out (row_data[r]),
         .any_vld  (row_any_vld[r])
      );
   end

   assign busy        = |row_any_vld;
   assign capture_now = bus.en && bus.in_vld && !bus.flush;

   always_comb begin
      mode_d = mode_q;
      if (!busy && !capture_now) begin
         mode_d = skew_mode_e'(bus.mode_req);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         mode_q <= SKEW;
      end else begin
         mode_q <= mode_d;
      end
   end

   assign bus.data_out = row_data;
   assign bus.out_vld  = row_vld;
   assign bus.mode_q   = mode_q;
   assign bus.busy     = busy;
   assign bus.all_vld  = &row_vld;

endmodule

// File: tb/tb_skew_buffer_array.sv
module tb_skew_buffer_array;

   localparam int NR = 4;
   localparam int W  = 16;

   logic clk;
   logic nrst;

   skew_buffer_array_if #(.ROWS(NR), .DW(W)) bus ();

   skew_buffer_array #(.ROWS(NR), .DW(W)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   // Each valid captured word is an item with its age in advancing edges;
   // it is visible on its row when age equals the row latency of the
   // current mode and lives until age exceeds the row's line depth.
   typedef struct {
      int           row;
      int           age;
      logic [W-1:0] data;
   } item_t;

   item_t items[$];
   logic  m_mode;

   function automatic int ref_depth(input int r);
      return (r + 1 > NR - r) ? r + 1 : NR - r;
   endfunction

   function automatic int ref_lat(input int r, input logic mode);
      return mode ? NR - r : r + 1;
   endfunction

   task automatic model_reset();
      items.delete();
      m_mode = 1'b0;
   endtask

   task automatic model_edge();
      item_t keep[$];
      bit    busy_pre;
      busy_pre = (items.size() != 0);
      if (!busy_pre && !(bus.en && bus.in_vld && !bus.flush))
         m_mode = bus.mode_req;
      if (bus.flush) begin
         items.delete();
      end else if (bus.en) begin
         foreach (items[i]) begin
            item_t it;
            it = items[i];
            it.age++;
            if (it.age <= ref_depth(it.row)) keep.push_back(it);
         end
         items = keep;
         if (bus.in_vld) begin
            for (int r = 0; r < NR; r++) begin
               item_t it;
               it.row  = r;
               it.age  = 1;
               it.data = bus.data_in[r];
               items.push_back(it);
            end
         end
      end
   endtask

   task automatic model_out(output logic [NR-1:0] v, output logic [NR*W-1:0] d);
      v = '0;
      d = '0;
      foreach (items[i]) begin
         if (items[i].age == ref_lat(items[i].row, m_mode)) begin
            v[items[i].row]               = 1'b1;
            d[items[i].row*W +: W]        = items[i].data;
         end
      end
   endtask

   // ---------------- helpers ----------------
   function automatic logic [NR*W-1:0] dout_word();
      logic [NR*W-1:0] v;
      for (int r = 0; r < NR; r++) v[r*W +: W] = bus.data_out[r];
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic en, input logic vld, input logic [NR*W-1:0] din);
      bus.en     = en;
      bus.in_vld = vld;
      for (int r = 0; r < NR; r++) bus.data_in[r] = din[r*W +: W];
   endtask

   task automatic tick();
      if (nrst) model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [NR-1:0]   v;
      logic [NR*W-1:0] d;
      model_out(v, d);
      chk({tag, "_vld"},     64'(bus.out_vld), 64'(v));
      chk({tag, "_data"},    64'(dout_word()), 64'(d));
      chk({tag, "_busy"},    64'(bus.busy),    64'(items.size() != 0));
      chk({tag, "_mode"},    64'(bus.mode_q),  64'(m_mode));
      chk({tag, "_all_vld"}, 64'(bus.all_vld), 64'(&v));
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_vld"},     64'(bus.out_vld), 64'(0));
      chk({tag, "_data"},    64'(dout_word()), 64'(0));
      chk({tag, "_busy"},    64'(bus.busy),    64'(0));
      chk({tag, "_all_vld"}, 64'(bus.all_vld), 64'(0));
   endtask

   // ---------------- table vectors ----------------
   typedef struct packed {
      logic            en;
      logic            in_vld;
      logic [NR*W-1:0] din;
      logic [NR-1:0]   exp_vld;
      logic [NR*W-1:0] exp_dout;
   } vec_t;

   function automatic vec_t mk(input logic en, input logic vld, input logic [NR*W-1:0] din,
                               input logic [NR-1:0] ev, input logic [NR*W-1:0] ed);
      vec_t v;
      v.en = en; v.in_vld = vld; v.din = din; v.exp_vld = ev; v.exp_dout = ed;
      return v;
   endfunction

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t            tbl [12];
      logic [NR*W-1:0] abcd;
      logic [NR*W-1:0] junk;
      logic [NR*W-1:0] d;

      abcd = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
      junk = {16'hEEEE, 16'hEEEE, 16'hEEEE, 16'hEEEE};

      // Single slice through SKEW, then the same slice with a two-cycle stall.
      tbl[0]  = mk(1, 1, abcd, 4'b0001, 64'h0000_0000_0000_000A);
      tbl[1]  = mk(1, 0, '0,   4'b0010, 64'h0000_0000_000B_0000);
      tbl[2]  = mk(1, 0, '0,   4'b0100, 64'h0000_000C_0000_0000);
      tbl[3]  = mk(1, 0, '0,   4'b1000, 64'h000D_0000_0000_0000);
      tbl[4]  = mk(1, 0, '0,   4'b0000, 64'h0);
      tbl[5]  = mk(1, 1, abcd, 4'b0001, 64'h0000_0000_0000_000A);
      tbl[6]  = mk(0, 1, junk, 4'b0001, 64'h0000_0000_0000_000A);
      tbl[7]  = mk(0, 1, junk, 4'b0001, 64'h0000_0000_0000_000A);
      tbl[8]  = mk(1, 0, '0,   4'b0010, 64'h0000_0000_000B_0000);
      tbl[9]  = mk(1, 0, '0,   4'b0100, 64'h0000_000C_0000_0000);
      tbl[10] = mk(1, 0, '0,   4'b1000, 64'h000D_0000_0000_0000);
      tbl[11] = mk(1, 0, '0,   4'b0000, 64'h0);

      nrst         = 1'b0;
      bus.flush    = 1'b0;
      bus.mode_req = 1'b0;
      set_in(0, 0, '0);
      model_reset();
      #3;
      check_idle("rst");
      chk("rst_mode", 64'(bus.mode_q), 64'(0));
      @(negedge clk);
      nrst = 1'b1;

      // ---- reset mid-stream, with DESKEW active beforehand ----
      bus.mode_req = 1'b1;
      tick();
      chk("pre_rst_mode", 64'(bus.mode_q), 64'(1));
      for (int k = 0; k < 3; k++) begin
         set_in(1, 1, {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
         tick();
         check_model("feed");
      end
      set_in(1, 0, '0);
      chk("pre_rst_busy", 64'(bus.busy), 64'(1));
      #2;
      nrst = 1'b0;
      #1;
      model_reset();
      check_idle("async_rst");
      chk("async_rst_mode", 64'(bus.mode_q), 64'(0));
      bus.mode_req = 1'b0;
      #2;
      nrst = 1'b1;

      // ---- table: SKEW latency and stall ----
      for (int i = 0; i < 12; i++) begin
         set_in(tbl[i].en, tbl[i].in_vld, tbl[i].din);
         tick();
         chk($sformatf("tbl%0d_vld", i),  64'(bus.out_vld), 64'(tbl[i].exp_vld));
         chk($sformatf("tbl%0d_data", i), 64'(dout_word()), 64'(tbl[i].exp_dout));
         check_model($sformatf("tbl%0d_m", i));
      end

      // ---- DESKEW alignment ----
      set_in(0, 0, '0);
      bus.mode_req = 1'b1;
      tick();
      chk("dsk_mode", 64'(bus.mode_q), 64'(1));
      for (int k = 0; k < 8; k++) begin
         if (k < 4) begin
            for (int r = 0; r < NR; r++)
               d[r*W +: W] = (r == k) ? 16'(16'h10 + r) : 16'(16'h0F00 + k * 16 + r);
            set_in(1, 1, d);
         end else begin
            set_in(1, 0, '0);
         end
         tick();
         chk($sformatf("dsk_all_vld_e%0d", k + 1), 64'(bus.all_vld), 64'(k == 3));
         if (k == 3)
            chk("dsk_aligned_data", 64'(dout_word()), 64'h0013_0012_0011_0010);
         check_model($sformatf("dsk%0d", k));
      end
      set_in(1, 0, '0);
      tick();
      tick();
      check_idle("dsk_drained");

      // ---- blocked mode change: capture and in-flight data both hold the mode ----
      for (int e = 1; e <= 6; e++) begin
         bus.mode_req = (e == 3) ? 1'b1 : 1'b0;
         if (e == 1) set_in(1, 1, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
         else        set_in(1, 0, '0);
         tick();
         chk($sformatf("blk_mode_e%0d", e), 64'(bus.mode_q), 64'((e >= 6) ? 0 : 1));
         chk($sformatf("blk_busy_e%0d", e), 64'(bus.busy),   64'(e <= 4));
         check_model($sformatf("blk%0d", e));
      end

      // ---- flush priority ----
      bus.mode_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_in(1, 1, {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
         tick();
         check_model("fl_feed");
      end
      chk("fl_busy_before", 64'(bus.busy), 64'(1));
      bus.flush = 1'b1;
      set_in(0, 1, {16'h5555, 16'h5555, 16'h5555, 16'h5555});
      tick();
      check_idle("fl_after");
      chk("fl_mode_hold", 64'(bus.mode_q), 64'(0));
      bus.flush = 1'b0;
      set_in(1, 0, '0);
      tick();
      chk("fl_mode_switch", 64'(bus.mode_q), 64'(1));
      for (int k = 0; k < 5; k++) begin
         tick();
         check_idle($sformatf("fl_drop%0d", k));
      end

      // ---- randomized traffic against the model ----
      for (int c = 0; c < 800; c++) begin
         bus.flush = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 9) == 0) bus.mode_req = ~bus.mode_req;
         set_in($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
                {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
         tick();
         check_model("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/skew_buffer_array.md
Name: skew_buffer_array

Overview:
- Parametrised skew/de-skew buffer array for the systolic PE grid.
- Per-row programmable delay lines carry data plus a valid tag.
- SKEW mode staggers row r by r+1 cycles on the PE input edge.
- DESKEW mode delays row r by ROWS-r cycles on the PE output edge, so a skewed wavefront leaves time-aligned.
- Adds over the previous fixed array: stall (hold) support, flush, per-row valid, runtime mode select, and busy/aligned status.

Parameters:
- ROWS, 25, number of channels (rows); min 1.
- DW, 16, data width per channel.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  advance; 0 = whole array holds (stall).
- flush  in  1  synchronous clear of all in-flight entries.
- mode_req  in  1  requested mode: 0 = SKEW, 1 = DESKEW.
- in_vld  in  1  data_in slice valid this cycle.
- data_in  in  ROWS x DW  unpacked array, one word per row.
- data_out  out  ROWS x DW  delayed data, registered.
- out_vld  out  ROWS  per-row valid of data_out.
- mode_q  out  1  active mode.
- busy  out  1  any valid entry in flight.
- all_vld  out  1  AND of out_vld.

Behaviour:
- Reset (nrst=0, async): every stage data=0 and vld=0; data_out=0; out_vld=0; mode_q=SKEW; busy=0; all_vld=0.
- Each row r has a shift line of length D_r = max(r+1, ROWS-r). Stage 0 captures {in_vld, in_vld ? data_in[r] : 0}.
- Output tap: stage r (SKEW) or stage ROWS-1-r (DESKEW). The tap drives data_out[r] and out_vld[r] directly; no extra register.
- Latency, counted in en=1 edges from capture:
  - SKEW: r+1 (row 0 = 1, row ROWS-1 = ROWS).
  - DESKEW: ROWS-r (row 0 = ROWS, row ROWS-1 = 1).
- en=0: no stage changes, outputs hold their values, inputs are ignored. Latency counts only en=1 edges.
- Invalid entries always carry data 0, so data_out=0 whenever out_vld[r]=0.
- flush=1: at the next edge all stages clear to data=0/vld=0, regardless of en. A concurrent in_vld slice is dropped. flush has priority over en.
- busy: combinational OR of all valid bits in all stages, including stages beyond the active tap.
- Mode switch: mode_q <= mode_req only at an edge where busy=0 and NOT(en && in_vld && !flush). Otherwise mode_req is ignored that cycle and re-evaluated every cycle. Consequences:
  - No in-flight data is ever re-tapped.
  - If flush is asserted while busy=1, busy reads 0 in the following cycle and the switch can happen at the edge after that.
  - A capture and a mode change never share an edge; the capture blocks the switch.
- Stages beyond the active tap keep shifting and are don't-care for outputs, but they do count toward busy.
- Width: pure transport, no arithmetic, no truncation.
- ROWS=1: D_0=1, both modes give 1-cycle latency.

Decomposition:
- Shared package cnn_array_pkg:
  - typedef enum logic {SKEW=1'b0, DESKEW=1'b1} skew_mode_e;
  - typedef logic [DW-1:0] word_t (package-level default DW=16);
  - function skew_depth(r, ROWS) returning max(r+1, ROWS-r).
- One sub-module, skew_delay_line:
  - Parameters DW and DEPTH.
  - Ports clk, nrst, en, flush, vld_in, data_in, tap_sel, vld_out, data_out, any_vld.
  - Instantiated once per row via generate.
  - The top computes tap_sel from mode_q and ORs any_vld into busy.

Test Plan (ROWS=4, DW=16):
- Reset mid-stream: feed 3 valid slices, assert nrst=0 asynchronously between edges -> out_vld=0, data_out=0, busy=0 immediately, mode_q=SKEW.
- SKEW latency: en=1, single slice in_vld=1, data_in={0x0A,0x0B,0x0C,0x0D} at edge 0 -> out_vld[0]=1 with 0x0A after edge 1, row1 0x0B after edge 2, row2 0x0C after edge 3, row3 0x0D after edge 4. Each row is valid for exactly one cycle and reads 0 otherwise.
- Stall: same stimulus with en=0 for cycles 2-3 -> row1 output appears after edge 4, row3 after edge 6. Outputs hold steady through the stall.
- DESKEW alignment:
  - Setup: mode_req=1 while idle -> mode_q=1 after one edge.
  - Stimulus: feed row r's value 0x10+r one edge later per row (row r at edge r).
  - Required response: all_vld=1 for exactly one cycle, after edge 4, with data_out={0x10,0x11,0x12,0x13}.
- Blocked mode change: mode_req toggled while busy=1 -> mode_q unchanged until the cycle after the last in-flight entry drains (busy=0). Also assert mode_req together with en=1/in_vld=1 while idle -> capture happens and the mode change is deferred.
- Flush priority: 4 slices in flight, assert flush=1 with en=0 and in_vld=1 -> after one edge busy=0 and out_vld=0, and the concurrent slice never appears on any output.
